rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- Round-robin arbiter granting exclusive ownership of one shared resource to one of N_REQ requesters.
- Ownership is an internal set/reset lock with two independent clear sources:
  - owner release (REQ drop or REL pulse);
  - hold-timeout watchdog.
- Sits between requesting blocks and the shared resource. BUSY/OWNER drive the resource's select mux.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OW, 2, width of OWNER; must equal ceil(log2(N_REQ)).
- TIMEOUT, 15, maximum hold cycles before forced release (2..2^TW-1).
- TW, 4, width of hold counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-high reset.
- REQ  input  N_REQ  level request per requester.
- REL  input  N_REQ  one-cycle release pulse per requester.
- GNT  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- BUSY  output  1  lock state; 1 while any GNT bit set.
- OWNER  output  OW  index of current/most recent owner.
- TOUT  output  1  one-cycle pulse on the cycle after a forced release.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; GNT=0; BUSY=0; OWNER=0; TOUT=0; hold counter=0.
  - Priority pointer=0 (requester 0 highest); block mask=0.
- States: IDLE, HOLD, GAP.
- IDLE:
  - Eligible set = REQ & ~block.
  - If non-empty at edge k: search starts at pointer and wraps; the first eligible index i wins.
  - After edge k: state=HOLD, GNT=1<<i, BUSY=1, OWNER=i, counter=0, pointer=(i+1) mod N_REQ.
  - If empty: stay in IDLE.
- HOLD:
  - Counter increments every cycle.
  - Normal release: REQ[OWNER]=0 or REL[OWNER]=1 at edge -> GAP.
  - Forced release: counter==TIMEOUT-1 at edge with no normal release -> GAP, TOUT=1 for the following cycle, block[OWNER]=1.
  - Release and timeout on the same edge: normal release wins, TOUT stays 0, no block.
  - REL/REQ changes from non-owners are ignored.
- GAP: exactly one cycle, GNT=0, BUSY=0, then IDLE. Guarantees a dead cycle between owners for resource-mux turnaround.
- Grant latency:
  - REQ sampled at edge k -> GNT visible after edge k.
  - Release at edge k -> earliest next GNT after edge k+2.
- Hold length: maximum TIMEOUT cycles with GNT high.
- Block mask:
  - block[j] clears on any edge where REQ[j]=0.
  - A timed-out requester cannot regain the lock until it has deasserted REQ for at least one edge.
- OWNER holds its last value in GAP/IDLE. TOUT=0 in every cycle except the one after a forced release.
- Reset mid-HOLD: GNT/BUSY drop asynchronously; pointer returns to 0; block mask clears.
- Fairness: with all requesters continuously requesting and releasing normally, grant order is 0,1,2,...,N_REQ-1,0,...
- TIMEOUT and TW mismatch (TIMEOUT >= 2^TW) is a configuration error; no runtime handling.

Test Plan:
- Reset then REQ=4'b1010 -> GNT=4'b0010, OWNER=1, BUSY=1 one edge later. REL[1] pulse -> GAP (GNT=0) for 1 cycle, then GNT=4'b1000, OWNER=3.
- REQ=4'b1111 held; each owner pulses REL two cycles after grant -> grant sequence 0,1,2,3,0 with one idle GAP cycle between each.
- REQ=4'b0001 held, no REL, TIMEOUT=15 -> GNT[0] high exactly 15 cycles, then TOUT=1 one cycle. Requester 0 is not re-granted while REQ[0] stays 1; dropping REQ[0] for 1 cycle and reasserting -> granted again.
- Owner 2 pulses REL[2] on the same edge the counter reaches 14 -> normal release, TOUT stays 0, requester 2 not blocked.
- Owner 1 in HOLD, REL[0] and REL[3] pulsed -> no effect, GNT stays 4'b0010.
- RST asserted mid-HOLD between clock edges -> GNT=0, BUSY=0, OWNER=0 immediately. After release with REQ=4'b1111 -> first grant goes to requester 0.

Source files
------------

// File: rtl/rr_lock_arbiter_if.sv
// rtl/rr_lock_arbiter_if.sv - requester/arbiter handshake bundle for rr_lock_arbiter
interface rr_lock_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int OW    = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic [OW-1:0]    owner;
  logic             tout;

  modport master (
    output req, rel,
    input  gnt, busy, owner, tout
  );

  modport slave (
    input  req, rel,
    output gnt, busy, owner, tout
  );
endinterface

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin lock arbiter with hold-timeout watchdog
// One owner at a time; a dead GAP cycle separates owners for the resource mux.
module rr_lock_arbiter #(
  parameter int N_REQ   = 4,
  parameter int OW      = 2,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_lock_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] block_q, block_d;
  logic             tout_q, tout_d;

  logic [N_REQ-1:0] elig;
  logic [OW-1:0]    win;
  logic             rel_now;

  // Scan in reverse so the last hit is the first index at or after ptr.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] e,
                                            input logic [OW-1:0]    ptr);
    logic [OW-1:0] w;
    int            idx;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (e[idx[OW-1:0]]) w = idx[OW-1:0];
    end
    return w;
  endfunction

  assign elig    = bus.req & ~block_q;
  assign win     = rr_pick(elig, ptr_q);
  assign rel_now = !bus.req[owner_q] || bus.rel[owner_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    block_d = block_q & bus.req;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d      = HOLD;
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          owner_d      = win;
          cnt_d        = '0;
          ptr_d        = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        // A normal release on the timeout edge wins: no TOUT, no block.
        if (rel_now) begin
          state_d = GAP;
          gnt_d   = '0;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d          = GAP;
          gnt_d            = '0;
          tout_d           = 1'b1;
          block_d[owner_q] = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      block_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.busy  = |gnt_q;
  assign bus.owner = owner_q;
  assign bus.tout  = tout_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - self-checking bench for rr_lock_arbiter
// Directed scenarios with literal expectations, then random traffic against a behavioural model.
module tb_rr_lock_arbiter;
  localparam int N       = 4;
  localparam int OWW     = 2;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_lock_arbiter_if #(.N_REQ(N), .OW(OWW)) bus ();

  rr_lock_arbiter #(.N_REQ(N), .OW(OWW), .TIMEOUT(TIMEOUT), .TW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the lock, for how many cycles, and who is locked out.
  bit         m_active;
  bit         m_gap;
  bit         m_tout;
  int         m_own;
  int         m_held;
  int         m_ptr;
  logic [N-1:0] m_blk;

  always @(posedge clk or posedge rst) begin : model
    bit           a, g, t;
    int           own, held, ptr, c;
    logic [N-1:0] nb;
    if (rst) begin
      m_active <= 1'b0; m_gap <= 1'b0; m_tout <= 1'b0;
      m_own <= 0; m_held <= 0; m_ptr <= 0; m_blk <= '0;
    end else begin
      a = m_active; g = m_gap; t = 1'b0;
      own = m_own; held = m_held; ptr = m_ptr;
      nb = m_blk & bus.req;
      if (m_active) begin
        held = held + 1;
        if (!bus.req[m_own] || bus.rel[m_own]) begin
          a = 1'b0; g = 1'b1;
        end else if (held == TIMEOUT) begin
          a = 1'b0; g = 1'b1; t = 1'b1; nb[m_own] = 1'b1;
        end
      end else if (m_gap) begin
        g = 1'b0;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!a && bus.req[c] && !m_blk[c]) begin
            a = 1'b1; own = c; held = 0; ptr = (c + 1) % N;
          end
        end
      end
      m_active <= a; m_gap <= g; m_tout <= t;
      m_own <= own; m_held <= held; m_ptr <= ptr; m_blk <= nb;
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      chk("cmp_gnt",   32'(bus.gnt),   m_active ? 32'(1 << m_own) : 32'd0);
      chk("cmp_busy",  32'(bus.busy),  32'(m_active));
      chk("cmp_owner", 32'(bus.owner), 32'(m_own));
      chk("cmp_tout",  32'(bus.tout),  32'(m_tout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (!bus.busy && n < 40) begin
      tick();
      n++;
    end
    chk(nm, 32'(bus.busy), 32'd1);
  endtask

  task automatic drain();
    bus.req = '0;
    bus.rel = '0;
    repeat (4) tick();
  endtask

  int order[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int hi_cnt;

  initial begin
    bus.req = '0;
    bus.rel = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt",   32'(bus.gnt),   32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_tout",  32'(bus.tout),  32'd0);
    tick();
    rst = 1'b0;
    cmp_on = 1'b1;

    // Pointer search starts at 0, then continues past the previous winner.
    bus.req = 4'b1010;
    tick();
    chk("t1_gnt",   32'(bus.gnt),   32'b0010);
    chk("t1_owner", 32'(bus.owner), 32'd1);
    chk("t1_busy",  32'(bus.busy),  32'd1);
    bus.rel = 4'b0010;
    tick();
    bus.rel = '0;
    chk("t1_gap", 32'(bus.gnt), 32'd0);
    tick();
    chk("t1_idle", 32'(bus.gnt), 32'd0);
    tick();
    chk("t1_gnt2",   32'(bus.gnt),   32'b1000);
    chk("t1_owner2", 32'(bus.owner), 32'd3);
    drain();

    // Fairness: everyone requesting, each owner releases two cycles after grant.
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_busy("t2_wait");
      order[g] = int'(bus.owner);
      tick();
      bus.rel = 4'(1 << order[g]);
      tick();
      bus.rel = '0;
      chk("t2_gap", 32'(bus.busy), 32'd0);
    end
    for (int g = 0; g < 5; g++) chk("t2_order", 32'(order[g]), 32'(exp_order[g]));
    drain();

    // Watchdog: exactly TIMEOUT cycles of grant, then TOUT and lock-out.
    bus.req = 4'b0001;
    wait_busy("t3_wait");
    hi_cnt = 0;
    while (bus.gnt[0] && hi_cnt < 40) begin
      hi_cnt++;
      tick();
    end
    chk("t3_hold_len", 32'(hi_cnt), 32'd15);
    chk("t3_tout", 32'(bus.tout), 32'd1);
    repeat (5) begin
      tick();
      chk("t3_blocked", 32'(bus.busy), 32'd0);
    end
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    wait_busy("t3_regrant");
    chk("t3_regrant_owner", 32'(bus.owner), 32'd0);
    drain();

    // Release on the same edge as the timeout: normal release wins.
    bus.req = 4'b0100;
    wait_busy("t4_wait");
    repeat (14) tick();
    chk("t4_still_held", 32'(bus.gnt), 32'b0100);
    bus.rel = 4'b0100;
    tick();
    bus.rel = '0;
    chk("t4_tout", 32'(bus.tout), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    wait_busy("t4_regrant");
    chk("t4_owner", 32'(bus.owner), 32'd2);
    drain();

    // Non-owner releases are ignored.
    bus.req = 4'b0010;
    wait_busy("t5_wait");
    bus.rel = 4'b1001;
    tick();
    bus.rel = '0;
    chk("t5_gnt_a", 32'(bus.gnt), 32'b0010);
    tick();
    chk("t5_gnt_b", 32'(bus.gnt), 32'b0010);
    drain();

    // Asynchronous reset mid-HOLD, then the pointer restarts at 0.
    bus.req = 4'b1111;
    wait_busy("t6_wait");
    chk("t6_pre_owner", 32'(bus.owner), 32'd2);
    #2;
    cmp_on = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt",   32'(bus.gnt),   32'd0);
    chk("t6_rst_busy",  32'(bus.busy),  32'd0);
    chk("t6_rst_owner", 32'(bus.owner), 32'd0);
    tick();
    rst = 1'b0;
    cmp_on = 1'b1;
    wait_busy("t6_wait2");
    chk("t6_first_gnt", 32'(bus.gnt), 32'b0001);
    drain();

    // Random traffic: slowly toggling requests, sparse release pulses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 15) == 0) bus.req[b] = ~bus.req[b];
        bus.rel[b] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
